// File: rtl/mux_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined N:1 selector tree.
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int clog2(input int v);
    int r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  function automatic int clog4(input int v);
    int r = 0;
    for (int p = 1; p < v; p = p * 4) r++;
    return r;
  endfunction

  function automatic int sel_w(input int n);
    return clog2(n);
  endfunction

  // Pipeline depth: one register rank per 4:1 tree level, never fewer than one.
  function automatic int lvls(input int n);
    return (clog4(n) < 1) ? 1 : clog4(n);
  endfunction

  // Leaves on tree level k; k = -1 yields the channel count itself.
  function automatic int nodes(input int n, input int k);
    int c = n;
    for (int j = 0; j <= k; j++) c = (c + 3) / 4;
    return c;
  endfunction

  // Index of the first leaf of level k in the flattened leaf numbering.
  function automatic int node_off(input int n, input int k);
    int o = 0;
    for (int j = 0; j < k; j++) o += nodes(n, j);
    return o;
  endfunction

endpackage

// File: rtl/mux_4x1_reg.sv
// Registered W-bit 4:1 leaf; valid/err/tag ride alongside the data one rank per leaf.
module mux_4x1_reg
  import mux_pkg::*;
#(
  parameter int W  = 1,
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    sel,
  input  logic [4*W-1:0] d,
  input  logic          valid,
  input  logic          err,
  input  logic [TW-1:0] tag,
  output logic [W-1:0]  q,
  output logic          q_valid,
  output logic          q_err,
  output logic [TW-1:0] q_tag
);

  // NOTE: non-blocking assignments so every rank samples its upstream rank's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      q_valid <= 1'b0;
      q_err   <= 1'b0;
      q_tag   <= '0;
    end else if (en) begin
      q_valid <= valid;
      // Payload only moves with a real sample, so a bubble leaves the last result in place.
      if (valid) begin
        q     <= d[sel*W +: W];
        q_err <= err;
        q_tag <= tag;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_pipe.sv
// Parametrised pipelined N:1 selector: a tree of registered 4:1 leaves plus an auto-scan
// channel sequencer. Out-of-range direct selects are flagged and return zero.
module mux_nx1_pipe
  import mux_pkg::*;
#(
  parameter int  N_IN  = 10,
  parameter int  W     = 1,
  parameter int  DWELL = 1,
  localparam int SW    = sel_w(N_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_IN*W-1:0] i,
  input  logic [SW-1:0]     s,
  input  logic              s_vld,
  input  logic              mode,
  output logic [W-1:0]      y,
  output logic              y_vld,
  output logic [SW-1:0]     y_ch,
  output logic              y_err
);

  localparam int LVLS  = lvls(N_IN);
  localparam int SELW  = 2 * LVLS;
  localparam int TOTAL = node_off(N_IN, LVLS);
  localparam int DWW   = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);
  localparam int NLW   = SELW + 1;

  localparam logic [NLW-1:0] N_LIM      = NLW'(N_IN);
  localparam logic [SW-1:0]  CH_LAST    = SW'(N_IN - 1);
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL - 1);

  logic [SW-1:0]     scan_ch;
  logic [DWW-1:0]    dwell_cnt;
  logic              launch;
  logic              launch_err;
  logic [SELW-1:0]   sel;
  logic [N_IN*W-1:0] src;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    launch        = (mode == MODE_SCAN) || s_vld;
    sel           = '0;
    sel[SW-1:0]   = (mode == MODE_SCAN) ? scan_ch : s;
    launch_err    = ({1'b0, sel} >= N_LIM);
    src           = launch_err ? '0 : i;
  end

  // Scan sequencer: DWELL launches per channel, wraps at N_IN-1, parked at 0 in direct mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_ch   <= '0;
      dwell_cnt <= '0;
    end else if (en) begin
      if (mode == MODE_DIRECT) begin
        scan_ch   <= '0;
        dwell_cnt <= '0;
      end else if (dwell_cnt == DWELL_LAST) begin
        dwell_cnt <= '0;
        scan_ch   <= (scan_ch == CH_LAST) ? '0 : scan_ch + 1'b1;
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
    end
  end

  logic [TOTAL*W-1:0]    leaf_d;
  logic [TOTAL-1:0]      leaf_v;
  logic [TOTAL-1:0]      leaf_e;
  logic [TOTAL*SELW-1:0] leaf_t;

  for (genvar k = 0; k < LVLS; k++) begin : g_lvl
    localparam int NN  = nodes(N_IN, k);
    localparam int NI  = nodes(N_IN, k - 1);
    localparam int OFF = node_off(N_IN, k);

    logic [4*NN*W-1:0] din;
    logic              v;
    logic              e;
    logic [SELW-1:0]   t;

    if (k == 0) begin : g_in
      always_comb begin
        din           = '0;
        din[NI*W-1:0] = src;
      end
      assign v = launch;
      assign e = launch_err;
      assign t = sel;
    end else begin : g_in
      // Every leaf of the previous level carries the same tag; leaf 0 is the one forwarded.
      localparam int POFF = node_off(N_IN, k - 1);
      always_comb begin
        din           = '0;
        din[NI*W-1:0] = leaf_d[POFF*W +: NI*W];
      end
      assign v = leaf_v[POFF];
      assign e = leaf_e[POFF];
      assign t = leaf_t[POFF*SELW +: SELW];
    end

    for (genvar n = 0; n < NN; n++) begin : g_leaf
      mux_4x1_reg #(
        .W  (W),
        .TW (SELW)
      ) u_leaf (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .sel     (t[2*k +: 2]),
        .d       (din[4*n*W +: 4*W]),
        .valid   (v),
        .err     (e),
        .tag     (t),
        .q       (leaf_d[(OFF+n)*W +: W]),
        .q_valid (leaf_v[OFF+n]),
        .q_err   (leaf_e[OFF+n]),
        .q_tag   (leaf_t[(OFF+n)*SELW +: SELW])
      );
    end
  end

  assign y     = leaf_d[(TOTAL-1)*W +: W];
  assign y_vld = leaf_v[TOTAL-1];
  assign y_err = leaf_e[TOTAL-1];
  assign y_ch  = leaf_t[(TOTAL-1)*SELW +: SW];

  // Side-band copies held by non-forwarded leaves are never read.
  logic unused_meta;
  assign unused_meta = ^{leaf_v, leaf_e, leaf_t};

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Self-checking bench: directed scenarios plus random traffic on a 10-channel instance and a
// sweep of channel counts, all compared against a queue-based delay-line reference model.
module tb_mux_nx1_pipe;

  localparam int N_MAIN = 10;
  localparam int L_MAIN = 2;
  localparam int DW_MAIN = 2;
  localparam int NS  [5] = '{2, 4, 5, 16, 17};
  localparam int SWS [5] = '{1, 2, 3, 4, 5};
  localparam int LS  [5] = '{1, 1, 2, 2, 3};

  typedef struct packed {
    logic       vld;
    logic [7:0] d;
    logic [4:0] ch;
    logic       err;
  } rec_t;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          mode;
  logic [79:0]   i10;
  logic [3:0]    s10;
  logic          s_vld10;
  logic [7:0]    y;
  logic          y_vld;
  logic [3:0]    y_ch;
  logic          y_err;

  logic [135:0]  isw;
  logic [4:0]    ssw;
  logic          vsw;
  logic [7:0]    sw_y  [5];
  logic          sw_v  [5];
  logic          sw_e  [5];
  logic [4:0]    sw_ch [5];

  int   checks;
  int   failures;
  int   scan_n;
  int   vld_seen;
  rec_t q_main[$];
  rec_t q_sw[5][$];
  rec_t exp_main;
  rec_t exp_sw[5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux_nx1_pipe #(
    .N_IN  (N_MAIN),
    .W     (8),
    .DWELL (DW_MAIN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .i     (i10),
    .s     (s10),
    .s_vld (s_vld10),
    .mode  (mode),
    .y     (y),
    .y_vld (y_vld),
    .y_ch  (y_ch),
    .y_err (y_err)
  );

  for (genvar j = 0; j < 5; j++) begin : g_sw
    localparam int NN  = NS[j];
    localparam int SWG = SWS[j];
    logic [SWG-1:0] ch;
    mux_nx1_pipe #(
      .N_IN  (NN),
      .W     (8),
      .DWELL (1)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .i     (isw[NN*8-1:0]),
      .s     (ssw[SWG-1:0]),
      .s_vld (vsw),
      .mode  (1'b0),
      .y     (sw_y[j]),
      .y_vld (sw_v[j]),
      .y_ch  (ch),
      .y_err (sw_e[j])
    );
    assign sw_ch[j] = 5'(ch);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: an L-deep delay line of launch records; outputs keep the last valid payload.
  task automatic model_reset();
    q_main   = {};
    exp_main = '0;
    scan_n   = 0;
    for (int k = 0; k < L_MAIN - 1; k++) q_main.push_back(rec_t'(0));
    for (int j = 0; j < 5; j++) begin
      q_sw[j]   = {};
      exp_sw[j] = '0;
      for (int k = 0; k < LS[j] - 1; k++) q_sw[j].push_back(rec_t'(0));
    end
  endtask

  function automatic rec_t retire(input rec_t cur, input rec_t o);
    rec_t r = cur;
    r.vld = o.vld;
    if (o.vld) begin
      r.d   = o.d;
      r.ch  = o.ch;
      r.err = o.err;
    end
    return r;
  endfunction

  task automatic model_edge();
    rec_t r;
    rec_t o;
    if (!rst_n || !en) return;
    r = '0;
    if (mode) begin
      r.vld  = 1'b1;
      r.ch   = 5'((scan_n / DW_MAIN) % N_MAIN);
      scan_n = scan_n + 1;
    end else begin
      scan_n = 0;
      r.vld  = s_vld10;
      r.ch   = 5'(s10);
    end
    r.err = (int'(r.ch) >= N_MAIN);
    if (!r.err) r.d = i10[int'(r.ch)*8 +: 8];
    q_main.push_back(r);
    o = q_main.pop_front();
    exp_main = retire(exp_main, o);
    for (int j = 0; j < 5; j++) begin
      r     = '0;
      r.vld = vsw;
      r.ch  = 5'(int'(ssw) % (1 << SWS[j]));
      r.err = (int'(r.ch) >= NS[j]);
      if (!r.err) r.d = isw[int'(r.ch)*8 +: 8];
      q_sw[j].push_back(r);
      o = q_sw[j].pop_front();
      exp_sw[j] = retire(exp_sw[j], o);
    end
  endtask

  task automatic compare();
    check("main_vld", 32'(y_vld), 32'(exp_main.vld));
    check("main_y", 32'(y), 32'(exp_main.d));
    if (exp_main.vld) begin
      check("main_ch", 32'(y_ch), 32'(exp_main.ch));
      check("main_err", 32'(y_err), 32'(exp_main.err));
    end
    for (int j = 0; j < 5; j++) begin
      check($sformatf("n%0d_vld", NS[j]), 32'(sw_v[j]), 32'(exp_sw[j].vld));
      check($sformatf("n%0d_y", NS[j]), 32'(sw_y[j]), 32'(exp_sw[j].d));
      if (exp_sw[j].vld) begin
        check($sformatf("n%0d_ch", NS[j]), 32'(sw_ch[j]), 32'(exp_sw[j].ch));
        check($sformatf("n%0d_err", NS[j]), 32'(sw_e[j]), 32'(exp_sw[j].err));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    en       = 1'b1;
    mode     = 1'b0;
    s10      = '0;
    s_vld10  = 1'b0;
    isw      = '0;
    ssw      = '0;
    vsw      = 1'b0;
    for (int k = 0; k < N_MAIN; k++) i10[k*8 +: 8] = 8'(8'h10 + k);
    model_reset();

    // Reset state.
    tick();
    check("rst_y", 32'(y), 32'h0);
    check("rst_vld", 32'(y_vld), 32'h0);
    check("rst_ch", 32'(y_ch), 32'h0);
    check("rst_err", 32'(y_err), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Direct walk over every channel, one launch per cycle.
    vld_seen = 0;
    for (int k = 0; k < N_MAIN; k++) begin
      s10 = 4'(k);
      s_vld10 = 1'b1;
      tick();
      vld_seen += int'(y_vld);
    end
    s_vld10 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vld_seen += int'(y_vld);
    end
    check("walk_vld_cycles", 32'(vld_seen), 32'd10);

    // Out-of-range selects followed immediately by a legal one.
    s10 = 4'd10; s_vld10 = 1'b1; tick();
    s10 = 4'd11; tick();
    s10 = 4'd15; tick();
    s10 = 4'd9;  tick();
    check("oor_ch", 32'(y_ch), 32'd15);
    check("oor_err", 32'(y_err), 32'd1);
    check("oor_y", 32'(y), 32'h0);
    check("oor_vld", 32'(y_vld), 32'd1);
    s_vld10 = 1'b0;
    tick();
    check("oor_next_y", 32'(y), 32'h19);
    check("oor_next_err", 32'(y_err), 32'd0);
    tick();
    tick();

    // Auto-scan; direct-mode inputs are noise and must be ignored.
    mode = 1'b1;
    for (int k = 0; k < 22; k++) begin
      s10     = 4'($urandom);
      s_vld10 = 1'($urandom);
      tick();
    end
    mode = 1'b0;
    s_vld10 = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    mode = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    mode = 1'b0;
    for (int k = 0; k < 3; k++) tick();

    // Stall while a sample is mid-pipe; launch requests during the stall are ignored.
    s10 = 4'd3; s_vld10 = 1'b1; tick();
    en = 1'b0; s10 = 4'd7;
    for (int k = 0; k < 5; k++) tick();
    s_vld10 = 1'b0; en = 1'b1; tick();
    check("stall_y", 32'(y), 32'h13);
    check("stall_vld", 32'(y_vld), 32'd1);
    check("stall_ch", 32'(y_ch), 32'd3);
    tick();
    check("stall_no_dup", 32'(y_vld), 32'd0);

    // Stall while y_vld is asserted: it must stay asserted.
    s10 = 4'd4; s_vld10 = 1'b1; tick();
    s_vld10 = 1'b0; tick();
    en = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("stall_hold_vld", 32'(y_vld), 32'd1);
    en = 1'b1;
    tick();
    tick();

    // Asynchronous reset between edges discards the in-flight sample.
    s10 = 4'd5; s_vld10 = 1'b1; tick();
    s_vld10 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_y", 32'(y), 32'h0);
    check("arst_vld", 32'(y_vld), 32'h0);
    tick();
    rst_n = 1'b1;
    vld_seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      vld_seen += int'(y_vld);
    end
    check("arst_flushed", 32'(vld_seen), 32'd0);

    // Random traffic on every instance, including stalls and mode changes.
    for (int c = 0; c < 240; c++) begin
      en      = ($urandom_range(0, 5) != 0);
      mode    = (((c / 25) % 2) == 1);
      s10     = 4'($urandom);
      s_vld10 = 1'($urandom);
      ssw     = 5'($urandom);
      vsw     = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N_MAIN; k++) i10[k*8 +: 8] = 8'($urandom);
      for (int k = 0; k < 17; k++) isw[k*8 +: 8] = 8'($urandom);
      tick();
    end
    en = 1'b1; mode = 1'b0; s_vld10 = 1'b0; vsw = 1'b0;
    for (int k = 0; k < 4; k++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
